mips_mem_bridge: RTL and testbench
==================================

Name: mips_mem_bridge

Overview:
- Parametrised data-memory bridge between the MIPS memory stage (memwriteM / aluoutM / writedataM / readdataM) and a split-handshake SRAM-like bus with variable latency.
- Replaces the fixed single-cycle data-memory assumption. Generates stallM for the hazard unit, holds load data while the pipeline is stalled elsewhere, honours flushM, and times out hung transactions.
- Instantiated inside the mips top, between the datapath and the external data bus.

Parameters:
ADDR_W, 32, bus address width; the low ADDR_W bits of aluoutM are forwarded.
DATA_W, 32, data width; must be a multiple of 8.
TIMEOUT, 255, max cycles in REQ+WAIT before abort; 0 disables the watchdog.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
memenM  in  1  memory-stage instruction is a load or store
memwriteM  in  DATA_W/8  byte write enables; nonzero means store
aluoutM  in  32  effective address
writedataM  in  DATA_W  store data, already lane-aligned
flushM  in  1  memory-stage instruction is cancelled
stall_in  in  1  pipeline is held by another source
stallM  out  1  bridge requests a pipeline stall
readdataM  out  DATA_W  load data returned to the pipeline
bus_err  out  1  one-cycle pulse on watchdog abort
bus_req  out  1  bus request
bus_we  out  1  bus write
bus_wstrb  out  DATA_W/8  bus byte strobes
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  request accepted
bus_data_ok  in  1  response valid / write done
bus_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (rst=0, asynchronous) sets state IDLE and clears all registered values. Outputs under reset: bus_req=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, readdataM=0, bus_err=0, abort flag=0, watchdog counter=0.
- States and transitions:
  - IDLE: if memenM & ~flushM, capture addr, wdata, wstrb=memwriteM and we=|memwriteM into registers, then go to REQ.
  - REQ: bus_req=1 and bus outputs are driven from the captured registers. On bus_addr_ok go to WAIT; bus_req drops the same edge. bus_data_ok is ignored in REQ; the bus contract puts data_ok at least 1 cycle after addr_ok.
  - WAIT: on bus_data_ok, capture bus_rdata into the hold buffer (loads only; stores leave the buffer unchanged). Then go to HOLD, or to IDLE if the abort flag is set.
  - HOLD: readdataM = hold buffer. Stay while stall_in=1; go to IDLE when stall_in=0.
- stallM is combinational: (IDLE & memenM & ~flushM) | REQ | WAIT. It is 0 in HOLD.
- Latency:
  - Minimum load is 4 cycles from memenM to data: IDLE, REQ, WAIT, then data in HOLD.
  - stallM deasserts in the first HOLD cycle.
  - A back-to-back access spends at least 1 IDLE cycle.
- readdataM holds the last captured value outside HOLD. Loads capture the full word; sign/zero extension and lane select stay in the datapath.
- Flush:
  - flushM in IDLE suppresses the request.
  - flushM in REQ or WAIT sets the abort flag. The bus transaction runs to completion, because a request is never retracted once raised. The bridge then returns to IDLE without entering HOLD, and the buffer is not updated.
  - The abort flag clears on entry to IDLE.
- Watchdog:
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT while still in REQ or WAIT:
    - bus_err pulses for 1 cycle and bus_req drops;
    - the buffer is set to 0;
    - the next state is HOLD, or IDLE if aborted.
  - TIMEOUT=0 disables the watchdog.
- Simultaneous events:
  - data_ok on the same edge as a timeout: data_ok wins and there is no error.
  - flushM on the same cycle as data_ok in WAIT: abort wins, so no HOLD and no buffer update.
- Counter width is clog2(TIMEOUT+1), with a minimum of 1. The counter never wraps; it saturates at TIMEOUT.

Test Plan:
- Load, addr_ok in first REQ cycle, data_ok 2 cycles later with rdata=32'hDEADBEEF, stall_in=0 -> stallM high 4 cycles; readdataM=32'hDEADBEEF in HOLD; bus_we=0.
- Store memwriteM=4'b0011, aluoutM=32'h1000_0004, writedataM=32'h0000_ABCD -> bus_req=1, bus_we=1, bus_wstrb=4'b0011, bus_addr=32'h1000_0004, bus_wdata=32'h0000_ABCD; readdataM unchanged.
- Load completes with stall_in=1 held 3 cycles -> state stays HOLD 3 cycles; readdataM stable at the captured value; stallM=0 throughout.
- flushM pulse during WAIT, then data_ok with rdata=32'h1234_5678 -> return to IDLE; readdataM keeps its previous value; no HOLD.
- TIMEOUT=4, addr_ok never asserted -> bus_err single pulse 4 cycles after REQ entry; bus_req drops; readdataM=0 in HOLD.
- rst driven low mid-WAIT, asynchronously between edges -> bus_req=0, stallM=0, all outputs 0 immediately; after release a new load proceeds normally.

Source files
------------

// File: rtl/mips_mem_bridge.sv
// Memory-stage bridge from the MIPS pipeline to a split-handshake SRAM-like bus.
// Variable latency: it stalls the pipeline, holds load data and handles flush and timeout.
module mips_mem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memenM,
    input  logic [DATA_W/8-1:0] memwriteM,
    input  logic [31:0]         aluoutM,
    input  logic [DATA_W-1:0]   writedataM,
    input  logic                flushM,
    input  logic                stall_in,
    output logic                stallM,
    output logic [DATA_W-1:0]   readdataM,
    output logic                bus_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                we_q;
    logic [DATA_W-1:0]   hold_q;
    logic                abort_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic start, active, data_done, abort_now, timeout_hit;

    assign start       = (state_q == S_IDLE) && memenM && !flushM;
    assign active      = (state_q == S_REQ) || (state_q == S_WAIT);
    assign data_done   = (state_q == S_WAIT) && bus_data_ok;
    // A flush seen on the completing cycle still cancels the access.
    assign abort_now   = abort_q || flushM;
    // A response arriving on the last watchdog cycle beats the timeout.
    assign timeout_hit = (TIMEOUT != 0) && active && (cnt_q == CNT_LAST) && !data_done;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: each combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ: begin
                if (timeout_hit)      state_d = abort_now ? S_IDLE : S_HOLD;
                else if (bus_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (data_done || timeout_hit) state_d = abort_now ? S_IDLE : S_HOLD;
            end
            S_HOLD: if (!stall_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // stallM is gated by reset so the hazard unit sees no stall while held in reset.
    always_comb begin
        bus_req = (state_q == S_REQ);
        stallM  = rst && (start || active);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            hold_q  <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= timeout_hit;

            if (start) begin
                addr_q  <= aluoutM[ADDR_W-1:0];
                wdata_q <= writedataM;
                wstrb_q <= memwriteM;
                we_q    <= |memwriteM;
            end

            // Saturating watchdog, restarted on every new request.
            if (start)
                cnt_q <= '0;
            else if (active && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);

            if (state_d == S_IDLE)
                abort_q <= 1'b0;
            else if (active && flushM)
                abort_q <= 1'b1;

            if (data_done && !abort_now && !we_q)
                hold_q <= bus_rdata;
            else if (timeout_hit)
                hold_q <= '0;
        end
    end

    assign bus_we    = we_q;
    assign bus_wstrb = wstrb_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign readdataM = hold_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Scoreboard bench for mips_mem_bridge: stimulus queues the expected bus requests
// and pipeline responses, and negedge monitors pop and compare them.
module tb_mips_mem_bridge;

    logic        clk;
    logic        rst;
    logic        memenM;
    logic [3:0]  memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        stall_in;
    logic        stallM;
    logic [31:0] readdataM;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    mips_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .memenM     (memenM),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .flushM     (flushM),
        .stall_in   (stall_in),
        .stallM     (stallM),
        .readdataM  (readdataM),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_wstrb  (bus_wstrb),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    int        n_checks = 0;
    int        n_errors = 0;
    int        stall_total = 0;
    logic      prev_req = 1'b0;
    logic      prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [31:0] d, input logic err);
        resp_exp_t r;
        r.rdata = d;
        r.err   = err;
        resp_q.push_back(r);
    endtask

    // Present an access for one IDLE cycle; on return the bridge is in its first REQ cycle.
    task automatic issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        bus_exp_t e;
        e.we    = |we;
        e.wstrb = we;
        e.addr  = addr;
        e.wdata = wdata;
        bus_q.push_back(e);
        memenM     = 1'b1;
        memwriteM  = we;
        aluoutM    = addr;
        writedataM = wdata;
        step();
        memenM    = 1'b0;
        memwriteM = 4'b0000;
    endtask

    // Bus slave: addr_ok after addr_lat REQ cycles, data_ok after data_lat idle WAIT cycles.
    // flush_idx selects the WAIT cycle carrying a flushM pulse (-1 for none).
    task automatic bus_txn(input int addr_lat, input int data_lat,
                           input logic [31:0] rdata, input int flush_idx);
        repeat (addr_lat) step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0;
        for (int i = 0; i < data_lat; i++) begin
            flushM = (i == flush_idx);
            step();
        end
        flushM      = (flush_idx == data_lat);
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
        step();
        bus_data_ok = 1'b0;
        flushM      = 1'b0;
    endtask

    // Bus monitor: each new request must match the oldest queued expectation.
    always @(negedge clk) begin
        bus_exp_t e;
        resp_exp_t r;
        if (!rst) begin
            prev_req   <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (bus_req && !prev_req) begin
                check("bus_q_has_entry", 32'(bus_q.size() > 0), 32'd1);
                if (bus_q.size() > 0) begin
                    e = bus_q.pop_front();
                    check("bus_we",    32'(bus_we),    32'(e.we));
                    check("bus_wstrb", 32'(bus_wstrb), 32'(e.wstrb));
                    check("bus_addr",  bus_addr,       e.addr);
                    check("bus_wdata", bus_wdata,      e.wdata);
                end
            end
            // A falling stallM marks completion: first HOLD cycle or aborted return to IDLE.
            if (prev_stall && !stallM) begin
                check("resp_q_has_entry", 32'(resp_q.size() > 0), 32'd1);
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                    check("resp_readdata", readdataM,      r.rdata);
                    check("resp_bus_err",  32'(bus_err),   32'(r.err));
                end
            end
            prev_req   <= bus_req;
            prev_stall <= stallM;
            if (stallM) stall_total <= stall_total + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish, got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s0;
        rst         = 1'b0;
        memenM      = 1'b0;
        memwriteM   = 4'b0000;
        aluoutM     = 32'h0;
        writedataM  = 32'h0;
        flushM      = 1'b0;
        stall_in    = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;

        // Reset state, with a live memenM to show stallM is held off under reset.
        #12;
        memenM = 1'b1;
        #1;
        check("rst_stallM",    32'(stallM),    32'd0);
        check("rst_bus_req",   32'(bus_req),   32'd0);
        check("rst_bus_we",    32'(bus_we),    32'd0);
        check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        check("rst_bus_addr",  bus_addr,       32'd0);
        check("rst_bus_wdata", bus_wdata,      32'd0);
        check("rst_readdataM", readdataM,      32'd0);
        check("rst_bus_err",   32'(bus_err),   32'd0);
        memenM = 1'b0;
        #1 rst = 1'b1;
        step();

        // Load: addr_ok in first REQ cycle, data_ok two cycles later -> 4 stall cycles.
        s0 = stall_total;
        expect_resp(32'hDEAD_BEEF, 1'b0);
        issue(4'b0000, 32'h0000_0100, 32'h0);
        bus_txn(0, 1, 32'hDEAD_BEEF, -1);
        @(negedge clk);
        #1;
        check("load_stall_cycles", 32'(stall_total - s0), 32'd4);
        step();
        step();

        // Store: bus fields checked by the monitor; readdataM must keep the last load.
        expect_resp(32'hDEAD_BEEF, 1'b0);
        issue(4'b0011, 32'h1000_0004, 32'h0000_ABCD);
        bus_txn(0, 0, 32'hFFFF_FFFF, -1);
        step();
        step();

        // Load finishing while another source stalls the pipeline for 3 cycles.
        expect_resp(32'hCAFE_F00D, 1'b0);
        issue(4'b0000, 32'h0000_0200, 32'h0);
        stall_in = 1'b1;
        bus_txn(1, 0, 32'hCAFE_F00D, -1);
        memenM = 1'b1;  // the stalled load stays in M; must not start a new access
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_stallM",   32'(stallM), 32'd0);
            check("hold_readdata", readdataM,   32'hCAFE_F00D);
            check("hold_no_req",   32'(bus_req), 32'd0);
            step();
        end
        stall_in = 1'b0;
        @(negedge clk);
        check("hold_release_stallM", 32'(stallM), 32'd0);
        step();
        memenM = 1'b0;
        step();

        // Flush during WAIT: transaction completes, no HOLD, buffer untouched.
        expect_resp(32'hCAFE_F00D, 1'b0);
        issue(4'b0000, 32'h0000_0300, 32'h0);
        bus_txn(0, 1, 32'h1234_5678, 0);
        @(negedge clk);
        check("flush_wait_readdata", readdataM, 32'hCAFE_F00D);
        step();

        // Flush on the same cycle as data_ok: abort wins.
        expect_resp(32'hCAFE_F00D, 1'b0);
        issue(4'b0000, 32'h0000_0304, 32'h0);
        bus_txn(0, 1, 32'h8765_4321, 1);
        step();

        // data_ok on the edge where the watchdog would expire: data wins, no error.
        expect_resp(32'h55AA_33CC, 1'b0);
        issue(4'b0000, 32'h0000_0400, 32'h0);
        bus_txn(0, 2, 32'h55AA_33CC, -1);
        step();
        step();

        // Flush in IDLE suppresses the request entirely.
        memenM = 1'b1;
        flushM = 1'b1;
        @(negedge clk);
        check("idle_flush_stallM", 32'(stallM), 32'd0);
        step();
        memenM = 1'b0;
        flushM = 1'b0;
        @(negedge clk);
        check("idle_flush_no_req", 32'(bus_req), 32'd0);
        step();

        // Asynchronous reset in the middle of a store's WAIT phase.
        issue(4'b1111, 32'h0000_0600, 32'hA5A5_5A5A);
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_bus_req",   32'(bus_req),   32'd0);
        check("arst_stallM",    32'(stallM),    32'd0);
        check("arst_bus_we",    32'(bus_we),    32'd0);
        check("arst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        check("arst_bus_addr",  bus_addr,       32'd0);
        check("arst_bus_wdata", bus_wdata,      32'd0);
        check("arst_readdataM", readdataM,      32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        step();

        // Normal load after reset release.
        expect_resp(32'h0BAD_F00D, 1'b0);
        issue(4'b0000, 32'h0000_0700, 32'h0);
        bus_txn(0, 0, 32'h0BAD_F00D, -1);
        step();
        step();

        // Watchdog: addr_ok never comes; abort after 4 cycles in REQ.
        expect_resp(32'h0000_0000, 1'b1);
        issue(4'b0000, 32'h0000_0800, 32'h0);
        repeat (3) step();
        @(negedge clk);
        check("to_req_still_high", 32'(bus_req), 32'd1);
        check("to_no_err_yet",     32'(bus_err), 32'd0);
        step();
        @(negedge clk);
        check("to_req_dropped",   32'(bus_req),  32'd0);
        check("to_err_pulse",     32'(bus_err),  32'd1);
        check("to_readdata_zero", readdataM,     32'd0);
        step();
        @(negedge clk);
        check("to_err_single", 32'(bus_err), 32'd0);
        step();
        step();

        check("bus_q_drained",  32'(bus_q.size()),  32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
